// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for push-button conditioning: repeat FSM encoding and
// default timing constants (also used by the clock-speed switcher).
package btn_conditioner_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    localparam int DEFAULT_N_BTN           = 5;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_REPEAT_DELAY    = 50_000_000;
    localparam int DEFAULT_REPEAT_PERIOD   = 10_000_000;

    // Counter width able to hold 0..max(a,b)-1, never narrower than one bit.
    function automatic int ctr_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One button: 2-flop synchronizer, stability-counter debounce, press/release
// pulses and a hold-to-repeat FSM. All outputs come straight from flops.
module btn_debounce_channel
    import btn_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic pulse_press,
    output logic pulse_release,
    output logic pulse_repeat
);

    localparam int CNT_W  = ctr_width(DEBOUNCE_CYCLES, DEBOUNCE_CYCLES);
    localparam int RCNT_W = ctr_width(REPEAT_DELAY, REPEAT_PERIOD);

    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    logic              s1_reg;
    logic              s2_reg;
    logic              level_reg, level_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              press_reg, press_next;
    logic              release_reg, release_next;
    logic              repeat_reg, repeat_next;
    rpt_state_t        state_reg, state_next;
    logic [RCNT_W-1:0] rcnt_reg, rcnt_next;

    logic differs;
    logic accept;
    logic rise;
    logic fall;

    assign differs = (s2_reg != level_reg);
    assign accept  = differs && (cnt_reg == CNT_LAST);
    assign rise    = accept && s2_reg;
    assign fall    = accept && !s2_reg;

    // Debounce: any sample agreeing with the current level restarts the count.
    always_comb begin
        level_next   = level_reg;
        cnt_next     = '0;
        press_next   = rise;
        release_next = fall;
        if (differs) begin
            if (cnt_reg == CNT_LAST) begin
                level_next = s2_reg;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    // Repeat FSM; release has priority over a coinciding repeat slot.
    always_comb begin
        state_next  = state_reg;
        rcnt_next   = rcnt_reg;
        repeat_next = 1'b0;
        case (state_reg)
            RPT_IDLE: begin
                rcnt_next = '0;
                if (rise) begin
                    state_next  = RPT_HOLD;
                    repeat_next = 1'b1;
                end
            end
            RPT_HOLD: begin
                if (fall) begin
                    state_next = RPT_IDLE;
                    rcnt_next  = '0;
                end else if (rcnt_reg == DELAY_LAST) begin
                    state_next  = RPT_REPEAT;
                    rcnt_next   = '0;
                    repeat_next = 1'b1;
                end else begin
                    rcnt_next = rcnt_reg + RCNT_W'(1);
                end
            end
            RPT_REPEAT: begin
                if (fall) begin
                    state_next = RPT_IDLE;
                    rcnt_next  = '0;
                end else if (rcnt_reg == PERIOD_LAST) begin
                    rcnt_next   = '0;
                    repeat_next = 1'b1;
                end else begin
                    rcnt_next = rcnt_reg + RCNT_W'(1);
                end
            end
            default: begin
                state_next = RPT_IDLE;
                rcnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg      <= 1'b0;
            s2_reg      <= 1'b0;
            level_reg   <= 1'b0;
            cnt_reg     <= '0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            repeat_reg  <= 1'b0;
            state_reg   <= RPT_IDLE;
            rcnt_reg    <= '0;
        end else begin
            s1_reg      <= btn_raw;
            s2_reg      <= s1_reg;
            level_reg   <= level_next;
            cnt_reg     <= cnt_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            repeat_reg  <= repeat_next;
            state_reg   <= state_next;
            rcnt_reg    <= rcnt_next;
        end
    end

    assign level         = level_reg;
    assign pulse_press   = press_reg;
    assign pulse_release = release_reg;
    assign pulse_repeat  = repeat_reg;

endmodule

// File: rtl/btn_conditioner.sv
// Board push-button conditioner: one independent debounce channel per button,
// outputs concatenated in {C, D, U, R, L} bit order.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int N_BTN           = DEFAULT_N_BTN,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
            btn_debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_chan (
                .clk           (clk),
                .rst           (rst),
                .btn_raw       (btn_raw[gi]),
                .level         (btn_level[gi]),
                .pulse_press   (btn_press[gi]),
                .pulse_release (btn_release[gi]),
                .pulse_repeat  (btn_repeat[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: scenarios queue expected pulse events,
// a monitor compares every cycle in which the DUT emits any pulse.
module tb_btn_conditioner;

    localparam int NB  = 5;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_repeat;

    btn_conditioner #(
        .N_BTN           (NB),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        int            cyc;
        logic [NB-1:0] level;
        logic [NB-1:0] press;
        logic [NB-1:0] rls;
        logic [NB-1:0] rpt;
    } ev_t;

    ev_t exp_q[$];
    int  cyc     = 0;
    int  base    = 0;
    int  n_check = 0;
    int  n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle carrying a pulse must match the next queued event.
    always begin
        ev_t e;
        @(posedge clk);
        #1;
        if (!rst && ((btn_press | btn_release | btn_repeat) != '0)) begin
            n_check++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: cycle %0d level=%b press=%b release=%b repeat=%b, required no pulse",
                         cyc, btn_level, btn_press, btn_release, btn_repeat);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || btn_level != e.level || btn_press != e.press ||
                    btn_release != e.rls || btn_repeat != e.rpt) begin
                    n_fail++;
                    $display("FAIL %s: got cycle %0d level=%b press=%b release=%b repeat=%b, required cycle %0d level=%b press=%b release=%b repeat=%b",
                             e.name, cyc, btn_level, btn_press, btn_release, btn_repeat,
                             e.cyc, e.level, e.press, e.rls, e.rpt);
                end else begin
                    $display("ok %s at cycle %0d", e.name, cyc);
                end
            end
        end
    end

    task automatic push_ev(input string name, input int rel, input logic [NB-1:0] lv,
                           input logic [NB-1:0] pr, input logic [NB-1:0] rl,
                           input logic [NB-1:0] rp);
        ev_t e;
        e.name  = name;
        e.cyc   = base + rel;
        e.level = lv;
        e.press = pr;
        e.rls   = rl;
        e.rpt   = rp;
        exp_q.push_back(e);
    endtask

    // First value of a scenario is sampled at scenario edge 0.
    task automatic start(input logic [NB-1:0] v);
        @(negedge clk);
        base    = cyc + 1;
        btn_raw = v;
    endtask

    task automatic hold(input logic [NB-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            btn_raw = v;
        end
    endtask

    task automatic check_zero(input string name);
        n_check++;
        if ({btn_level, btn_press, btn_release, btn_repeat} != '0) begin
            n_fail++;
            $display("FAIL %s: got level=%b press=%b release=%b repeat=%b, required all zero",
                     name, btn_level, btn_press, btn_release, btn_repeat);
        end else begin
            $display("ok %s outputs zero", name);
        end
    endtask

    task automatic drain(input string name);
        n_check++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing: got %0d events still pending, required 0 (next %s at cycle %0d)",
                     name, exp_q.size(), exp_q[0].name, exp_q[0].cyc);
            exp_q.delete();
        end else begin
            $display("ok %s all events seen", name);
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst     = 1'b1;
        btn_raw = '0;
        #1;
        check_zero(name);
        @(negedge clk);
        rst = 1'b0;
        hold('0, 2);
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = '0;
        repeat (3) @(negedge clk);
        check_zero("power_on_reset");
        rst = 1'b0;
        hold('0, 2);

        // Clean press on bit 2, released later.
        start(5'b00100);
        push_ev("clean_press",   5, 5'b00100, 5'b00100, 5'b00000, 5'b00100);
        push_ev("clean_release", 12, 5'b00000, 5'b00000, 5'b00100, 5'b00000);
        hold(5'b00100, 6);
        hold(5'b00000, 20);
        drain("clean");
        do_reset("reset_after_clean");

        // Glitch of DEB-1 cycles is rejected.
        start(5'b00001);
        hold(5'b00001, 2);
        hold(5'b00000, 15);
        drain("glitch_short");

        // Pulse of exactly DEB cycles is accepted.
        start(5'b00001);
        push_ev("glitch_min_press",   5, 5'b00001, 5'b00001, 5'b00000, 5'b00001);
        push_ev("glitch_min_release", 9, 5'b00000, 5'b00000, 5'b00001, 5'b00000);
        hold(5'b00001, 3);
        hold(5'b00000, 15);
        drain("glitch_min");
        do_reset("reset_after_glitch");

        // Bounce 1,0,1,0,1 then hold: exactly one press.
        start(5'b00010);
        push_ev("bounce_press",   9, 5'b00010, 5'b00010, 5'b00000, 5'b00010);
        push_ev("bounce_release", 17, 5'b00000, 5'b00000, 5'b00010, 5'b00000);
        hold(5'b00000, 1);
        hold(5'b00010, 1);
        hold(5'b00000, 1);
        hold(5'b00010, 8);
        hold(5'b00000, 15);
        drain("bounce");
        do_reset("reset_after_bounce");

        // Auto-repeat on bit 3, held edges 0..29.
        start(5'b01000);
        push_ev("repeat_press", 5, 5'b01000, 5'b01000, 5'b00000, 5'b01000);
        push_ev("repeat_delay", 15, 5'b01000, 5'b00000, 5'b00000, 5'b01000);
        for (int t = 18; t <= 33; t += RP)
            push_ev("repeat_period", t, 5'b01000, 5'b00000, 5'b00000, 5'b01000);
        push_ev("repeat_release", 35, 5'b00000, 5'b00000, 5'b01000, 5'b00000);
        hold(5'b01000, 29);
        hold(5'b00000, 15);
        drain("repeat");
        do_reset("reset_after_repeat");

        // Simultaneous press on bits 4 and 0.
        start(5'b10001);
        push_ev("simul_press",   5, 5'b10001, 5'b10001, 5'b00000, 5'b10001);
        push_ev("simul_release", 12, 5'b00000, 5'b00000, 5'b10001, 5'b00000);
        hold(5'b10001, 6);
        hold(5'b00000, 15);
        drain("simul");
        do_reset("reset_after_simul");

        // Reset mid-hold, button kept pressed through it.
        start(5'b00010);
        push_ev("midrst_press1", 5, 5'b00010, 5'b00010, 5'b00000, 5'b00010);
        push_ev("midrst_press2", 13, 5'b00010, 5'b00010, 5'b00000, 5'b00010);
        push_ev("midrst_release", 20, 5'b00000, 5'b00000, 5'b00010, 5'b00000);
        hold(5'b00010, 6);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("reset_mid_hold");
        @(negedge clk);
        rst = 1'b0;
        hold(5'b00010, 6);
        hold(5'b00000, 20);
        drain("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Input conditioning stage between the board push-buttons and the CPU top level. It synchronizes each raw button into the fast system clock domain and debounces it with a per-button stability counter. It produces a clean level plus single-cycle press, release and auto-repeat pulses. The top level consumes these for reset, go, display-mode change and clock-speed up/down, instead of the raw pad signals.

## Interface
Parameters:
- `N_BTN`, 5: number of buttons, bit order {C, D, U, R, L} = [4:0].
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz); must be ≥ 2.
- `REPEAT_DELAY`, 50_000_000: cycles from press to first auto-repeat pulse.
- `REPEAT_PERIOD`, 10_000_000: cycles between subsequent auto-repeat pulses.

Ports:
- `clk`, in, 1: system clock (board oscillator, undivided).
- `rst`, in, 1: reset. One clock; reset is asynchronous and active-high.
- `btn_raw`, in, N_BTN: raw pad inputs, asynchronous, active-high.
- `btn_level`, out, N_BTN: debounced level.
- `btn_press`, out, N_BTN: one-cycle pulse on accepted 0→1.
- `btn_release`, out, N_BTN: one-cycle pulse on accepted 1→0.
- `btn_repeat`, out, N_BTN: one-cycle pulse on press and on each auto-repeat while held.

## Operation
- All outputs are registered. Reset drives every output to 0, clears both synchronizer flops, and clears all counters. States go to IDLE.
- Each bit uses a 2-flop synchronizer (s1→s2). Only s2 is used downstream.
- Debounce, per bit, uses counter `cnt` of width $clog2(DEBOUNCE_CYCLES):
  - On an edge where s2 == btn_level: `cnt` ← 0.
  - On an edge where s2 != btn_level and `cnt` < DEBOUNCE_CYCLES-1: `cnt` increments.
  - On an edge where s2 != btn_level and `cnt` == DEBOUNCE_CYCLES-1: btn_level toggles and `cnt` ← 0.
  - Any bounce back to the current level restarts the count.
- Pulse generation: btn_press or btn_release is high for exactly the cycle in which btn_level first shows the new value.
- Per-bit repeat FSM:
  - IDLE: leaves on accepted press → HOLD. Loads `rcnt` ← 0 and asserts btn_repeat with btn_press.
  - HOLD: `rcnt` counts. At `rcnt` == REPEAT_DELAY-1 it pulses btn_repeat, resets `rcnt` and goes → REPEAT.
  - REPEAT: at `rcnt` == REPEAT_PERIOD-1 it pulses btn_repeat and resets `rcnt`.
  - HOLD or REPEAT → IDLE on accepted release. No repeat pulse is issued in the release cycle, and `rcnt` is cleared.
  - `rcnt` width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
- Bits are fully independent. Simultaneous presses produce simultaneous pulses.

## Timing
- If raw changes and is first sampled at edge k and then held stable, btn_level/btn_press/btn_release update after edge k+DEBOUNCE_CYCLES+1. Pulses deassert after the following edge.
- A raw pulse of DEBOUNCE_CYCLES-1 cycles or shorter is rejected. A pulse of DEBOUNCE_CYCLES cycles is accepted.
- With the press visible after edge P, btn_repeat fires after edges P, P+REPEAT_DELAY, P+REPEAT_DELAY+n·REPEAT_PERIOD (n ≥ 1) while the level stays high.
- Release is seen after edge Q. A repeat slot coinciding with Q is suppressed.
- Reset asserted mid-count or mid-hold takes effect immediately. After deassert, a still-held button goes through a full debounce again and produces a fresh btn_press.

## Structure
- A shared header holds the repeat FSM state encoding (IDLE=2'd0, HOLD=2'd1, REPEAT=2'd2) and default timing constants. The clock-speed switcher reuses the same constants.
- There is one sub-module, `btn_debounce_channel`, which implements a single bit: synchronizer, debounce counter, pulse and repeat FSM. It is instantiated N_BTN times in a generate loop. The top wrapper only concatenates outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_BTN=5.
- Clean press: btn_raw[2] high from edge 0, held → btn_level[2]=1 and btn_press[2]=1 after edge 5, btn_press[2]=0 after edge 6. Other bits stay 0.
- Glitch filter: btn_raw[0] high for edges 0–2 only → no level or pulse change. Repeating with edges 0–3 high → level rises after edge 5 and falls after edge 9, with btn_release[0] after edge 9.
- Bounce: raw toggles 1,0,1,0,1 on edges 0–4, then holds 1 → press after edge 9 only, and exactly one btn_press.
- Auto-repeat: btn_raw[3] held edges 0–29, then low → btn_repeat after edges 5,15,18,21,24,27,30,33, btn_release after edge 35, and no repeat at 36.
- Simultaneous buttons: btn_raw = 5'b10001 at edge 0 → btn_press = 5'b10001 in the same cycle, after edge 5.
- Reset mid-hold: raw[1] held from edge 0, rst pulsed at edge 7 → all outputs 0 immediately. After deassert at edge 8, a new btn_press[1] follows once a full debounce completes.
